// File: rtl/instruction_decoder.sv
// instruction_decoder: registers the program-memory byte into ir and decodes jumps, moves, loads and ALU ops.
// Define DECODER_STATS_EN to build the retired-instruction counter; otherwise instr_count is tied to zero.
module instruction_decoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pm_data,
  input  logic        hold,
  input  logic        alu_zero,
  output logic        sync_reset,
  output logic [7:0]  ir,
  output logic        jmp,
  output logic        jmp_nz,
  output logic [3:0]  jmp_addr,
  output logic        dont_jmp,
  output logic        NOPC8,
  output logic        NOPCF,
  output logic        NOPD8,
  output logic        NOPDF,
  output logic        ld_en,
  output logic        mov_en,
  output logic        alu_en,
  output logic        rel_br,
  output logic [15:0] instr_count
);
  typedef enum logic [1:0] {RESET, FLUSH, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [7:0] ir_q, ir_d;
  logic z_q, z_d;
  logic load, v;
  logic [3:0] hi;
`ifdef DECODER_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? cnt_q + 16'd1 : cnt_q;
  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif
  assign sync_reset = s2_q;
  assign ir = ir_q;
  assign dont_jmp = z_q;
  assign hi = ir_q[7:4];
  assign v = !s2_q;
  always_comb begin
    load = !hold && (state_q == RUN || state_q == HOLD);
    state_d = state_q == RESET ? FLUSH : state_q == FLUSH ? RUN : hold ? HOLD : RUN;
    ir_d = load ? pm_data : ir_q;
    jmp = v && hi == 4'hE;
    jmp_nz = v && hi == 4'hF;
    jmp_addr = v ? ir_q[3:0] : 4'h0;
    rel_br = v && hi == 4'h1;
    ld_en = v && ir_q[7:6] == 2'b00 && hi != 4'h1;
    mov_en = v && ir_q[7:6] == 2'b01;
    alu_en = v && ir_q[7:6] == 2'b10;
    NOPC8 = v && ir_q == 8'hC8;
    NOPCF = v && ir_q == 8'hCF;
    NOPD8 = v && ir_q == 8'hD8;
    NOPDF = v && ir_q == 8'hDF;
    z_d = (load && alu_en) ? alu_zero : z_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= RESET;
      ir_q <= 8'h00;
      z_q <= 1'b0;
`ifdef DECODER_STATS_EN
      cnt_q <= 16'h0000;
`endif
    end else begin
      s1_q <= 1'b0;
      s2_q <= s1_q;
      state_q <= state_d;
      ir_q <= ir_d;
      z_q <= z_d;
`ifdef DECODER_STATS_EN
      cnt_q <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: directed vector table plus hand-written reset, hold and wrap sequences.
module tb_instruction_decoder;
  logic clk, reset_n, hold, alu_zero;
  logic [7:0] pm_data;
  logic sync_reset, jmp, jmp_nz, dont_jmp, NOPC8, NOPCF, NOPD8, NOPDF, ld_en, mov_en, alu_en, rel_br;
  logic [7:0] ir;
  logic [3:0] jmp_addr;
  logic [15:0] instr_count;
  int checks = 0, errors = 0, n_loads = 0;
  localparam logic [9:0] D_J = 10'h200, D_JNZ = 10'h100, D_REL = 10'h080, D_LD = 10'h040,
    D_MOV = 10'h020, D_ALU = 10'h010, D_C8 = 10'h008, D_CF = 10'h004, D_D8 = 10'h002,
    D_DF = 10'h001, D_NONE = 10'h000;
  typedef struct packed {
    logic [7:0] pm;
    logic       az;
    logic [9:0] dec;
    logic       z;
  } vec_t;
  vec_t tv [16];
  logic [9:0] dec;
  assign dec = {jmp, jmp_nz, rel_br, ld_en, mov_en, alu_en, NOPC8, NOPCF, NOPD8, NOPDF};

  instruction_decoder dut (
    .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .hold(hold), .alu_zero(alu_zero),
    .sync_reset(sync_reset), .ir(ir), .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr),
    .dont_jmp(dont_jmp), .NOPC8(NOPC8), .NOPCF(NOPCF), .NOPD8(NOPD8), .NOPDF(NOPDF),
    .ld_en(ld_en), .mov_en(mov_en), .alu_en(alu_en), .rel_br(rel_br), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cexp(input int n);
`ifdef DECODER_STATS_EN
    return n[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    tv[0]  = '{8'h83, 1'b1, D_ALU,  1'b0};
    tv[1]  = '{8'hF2, 1'b1, D_JNZ,  1'b1};
    tv[2]  = '{8'hC8, 1'b0, D_C8,   1'b1};
    tv[3]  = '{8'hCF, 1'b0, D_CF,   1'b1};
    tv[4]  = '{8'hD8, 1'b0, D_D8,   1'b1};
    tv[5]  = '{8'hDF, 1'b0, D_DF,   1'b1};
    tv[6]  = '{8'hC9, 1'b0, D_NONE, 1'b1};
    tv[7]  = '{8'h15, 1'b0, D_REL,  1'b1};
    tv[8]  = '{8'h2A, 1'b0, D_LD,   1'b1};
    tv[9]  = '{8'h47, 1'b0, D_MOV,  1'b1};
    tv[10] = '{8'h9C, 1'b0, D_ALU,  1'b1};
    tv[11] = '{8'hE3, 1'b0, D_J,    1'b0};
    tv[12] = '{8'h00, 1'b1, D_LD,   1'b0};
    tv[13] = '{8'hBF, 1'b1, D_ALU,  1'b0};
    tv[14] = '{8'hA1, 1'b1, D_ALU,  1'b1};
    tv[15] = '{8'h70, 1'b0, D_MOV,  1'b0};
    reset_n = 1'b0; hold = 1'b0; alu_zero = 1'b0; pm_data = 8'hE5;
    #12;
    chk("rst_ir", ir, 8'h00);
    chk("rst_dec", dec, D_NONE);
    chk("rst_sync", sync_reset, 1'b1);
    chk("rst_z", dont_jmp, 1'b0);
    chk("rst_cnt", instr_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("flush_sync", sync_reset, 1'b1);
    chk("flush_dec", dec, D_NONE);
    tick();
    chk("run_sync", sync_reset, 1'b0);
    chk("run_ir_not_loaded", ir, 8'h00);
    tick(); n_loads++;
    chk("first_ir", ir, 8'hE5);
    chk("first_jmp", dec, D_J);
    chk("first_addr", jmp_addr, 4'h5);
    chk("first_cnt", instr_count, cexp(n_loads));
    // az in each vector is the ALU result for the instruction already in ir
    for (int i = 0; i < 16; i++) begin
      pm_data = tv[i].pm; alu_zero = tv[i].az;
      tick(); n_loads++;
      chk($sformatf("vec%0d_ir", i), ir, tv[i].pm);
      chk($sformatf("vec%0d_dec", i), dec, tv[i].dec);
      chk($sformatf("vec%0d_addr", i), jmp_addr, tv[i].pm[3:0]);
      chk($sformatf("vec%0d_z", i), dont_jmp, tv[i].z);
      chk($sformatf("vec%0d_cnt", i), instr_count, cexp(n_loads));
    end
    pm_data = 8'h8F; alu_zero = 1'b0;
    tick(); n_loads++;
    chk("pre_hold_ir", ir, 8'h8F);
    hold = 1'b1; alu_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pm_data = 8'h10 + 8'(i);
      tick();
      chk($sformatf("hold%0d_ir", i), ir, 8'h8F);
      chk($sformatf("hold%0d_z", i), dont_jmp, 1'b0);
      chk($sformatf("hold%0d_alu", i), dec, D_ALU);
      chk($sformatf("hold%0d_cnt", i), instr_count, cexp(n_loads));
    end
    hold = 1'b0; pm_data = 8'hE9;
    tick(); n_loads++;
    chk("resume_ir", ir, 8'hE9);
    chk("resume_z", dont_jmp, 1'b1);
    chk("resume_cnt", instr_count, cexp(n_loads));
    pm_data = 8'h86; alu_zero = 1'b1;
    tick(); n_loads++;
    chk("mid_pre_alu", alu_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_ir", ir, 8'h00);
    chk("mid_z", dont_jmp, 1'b0);
    chk("mid_cnt", instr_count, 16'h0000);
    chk("mid_sync", sync_reset, 1'b1);
    chk("mid_dec", dec, D_NONE);
    #1 reset_n = 1'b1;
    n_loads = 0; hold = 1'b1; pm_data = 8'h3C;
    tick();
    chk("mid_flush_sync", sync_reset, 1'b1);
    chk("mid_flush_ir", ir, 8'h00);
    tick();
    chk("mid_run_sync", sync_reset, 1'b0);
    hold = 1'b0;
    tick(); n_loads++;
    chk("mid_reload_ir", ir, 8'h3C);
    chk("mid_reload_dec", dec, D_LD);
    chk("mid_reload_cnt", instr_count, cexp(n_loads));
`ifdef DECODER_STATS_EN
    pm_data = 8'h00;
    while (n_loads < 32'hFFFE) begin
      tick(); n_loads++;
    end
    chk("wrap_fffe", instr_count, 16'hFFFE);
    tick();
    chk("wrap_ffff", instr_count, 16'hFFFF);
    tick();
    chk("wrap_0000", instr_count, 16'h0000);
    tick();
    chk("wrap_0001", instr_count, 16'h0001);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
